// File: rtl/rle_encoder.sv
// Run-length encoder: folds a valid/ready symbol stream into registered (symbol, count, last) pairs.
// States: EMPTY = no open run | RUN = run open in r_cur_sym/r_cur_cnt | TAIL = lone closing symbol waiting for the output slot
module rle_encoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_symbol,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_last
);

    localparam logic [COUNT_WIDTH-1:0] MAX_RUN = '1;
    localparam logic [COUNT_WIDTH-1:0] ONE     = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        TAIL  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_cur_sym, w_cur_sym_nxt;
    logic [COUNT_WIDTH-1:0] r_cur_cnt, w_cur_cnt_nxt;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_symbol;
    logic [COUNT_WIDTH-1:0] r_out_count;
    logic                   r_out_last;

    logic                   w_slot_free;
    logic                   w_accept;
    logic                   w_extend;
    logic                   w_emit;
    logic [DATA_WIDTH-1:0]  w_emit_sym;
    logic [COUNT_WIDTH-1:0] w_emit_cnt;
    logic                   w_emit_last;

    // Every state that emits is only entered via an accepted beat or a free slot, so a pending pair is never overwritten.
    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = reset && w_slot_free && (r_state != TAIL);
    assign w_accept    = in_valid && in_ready;
    assign w_extend    = (in_data == r_cur_sym) && (r_cur_cnt != MAX_RUN);

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_sym_nxt = r_cur_sym;
        w_cur_cnt_nxt = r_cur_cnt;
        w_emit        = 1'b0;
        w_emit_sym    = r_cur_sym;
        w_emit_cnt    = r_cur_cnt;
        w_emit_last   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_emit      = 1'b1;
                        w_emit_sym  = in_data;
                        w_emit_cnt  = ONE;
                        w_emit_last = 1'b1;
                    end else begin
                        w_cur_sym_nxt = in_data;
                        w_cur_cnt_nxt = ONE;
                        w_state_nxt   = RUN;
                    end
                end
            end
            RUN: begin
                if (w_accept) begin
                    if (w_extend) begin
                        if (in_last) begin
                            w_emit      = 1'b1;
                            w_emit_cnt  = r_cur_cnt + ONE;
                            w_emit_last = 1'b1;
                            w_state_nxt = EMPTY;
                        end else begin
                            w_cur_cnt_nxt = r_cur_cnt + ONE;
                        end
                    end else begin
                        w_emit        = 1'b1;
                        w_cur_sym_nxt = in_data;
                        w_cur_cnt_nxt = ONE;
                        w_state_nxt   = in_last ? TAIL : RUN;
                    end
                end
            end
            TAIL: begin
                if (w_slot_free) begin
                    w_emit      = 1'b1;
                    w_emit_cnt  = ONE;
                    w_emit_last = 1'b1;
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= EMPTY;
            r_cur_sym <= '0;
            r_cur_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_sym <= w_cur_sym_nxt;
            r_cur_cnt <= w_cur_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_symbol <= '0;
            r_out_count  <= '0;
            r_out_last   <= 1'b0;
        end else if (w_emit) begin
            r_out_valid  <= 1'b1;
            r_out_symbol <= w_emit_sym;
            r_out_count  <= w_emit_cnt;
            r_out_last   <= w_emit_last;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_symbol = r_out_symbol;
    assign out_count  = r_out_count;
    assign out_last   = r_out_last;

endmodule

// File: tb/tb_rle_encoder.sv
// Bench for rle_encoder: directed frames plus randomized handshakes, checked against a run-splitting model.
module tb_rle_encoder;

    typedef struct packed { logic [7:0] s; logic [7:0] c; logic l; } pair_t;
    typedef struct packed { logic [7:0] d; logic l; } beat_t;

    logic       clk, reset;
    logic       in_valid, in_last, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, out_last;
    logic [7:0] out_symbol, out_count;
    logic       s_in_ready, s_out_valid, s_out_last;
    logic [7:0] s_out_symbol;
    logic [1:0] s_out_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_low_en = 0;
    int ready_low_cnt = 0;

    beat_t acc_q[$];
    pair_t cap_q[$];
    pair_t caps_q[$];
    pair_t exp_q[$];

    rle_encoder #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_symbol(out_symbol), .out_count(out_count),
        .out_last(out_last)
    );

    rle_encoder #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_symbol(s_out_symbol), .out_count(s_out_count),
        .out_last(s_out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic pair_t mk(input logic [7:0] s, input logic [7:0] c, input logic l);
        pair_t p;
        p.s = s;
        p.c = c;
        p.l = l;
        return p;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (in_valid && in_ready) acc_q.push_back({in_data, in_last});
            if (out_valid && out_ready) cap_q.push_back(mk(out_symbol, out_count, out_last));
            if (s_out_valid && out_ready) caps_q.push_back(mk(s_out_symbol, {6'b0, s_out_count}, s_out_last));
            if (mon_low_en && !in_ready) ready_low_cnt++;
        end
    end

    // Reference: group each frame into maximal runs, then cut every run into MAX-sized pieces plus remainder.
    function automatic void push_run(input logic [7:0] sym, input int len, input logic last, input int maxr);
        int rem = len;
        while (rem > maxr) begin
            exp_q.push_back(mk(sym, 8'(maxr), 1'b0));
            rem -= maxr;
        end
        exp_q.push_back(mk(sym, 8'(rem), last));
    endfunction

    function automatic void build_expected(input int maxr);
        int len = 0;
        logic [7:0] sym = '0;
        exp_q.delete();
        foreach (acc_q[i]) begin
            if (len > 0 && acc_q[i].d != sym) begin
                push_run(sym, len, 1'b0, maxr);
                len = 0;
            end
            if (len == 0) sym = acc_q[i].d;
            len++;
            if (acc_q[i].l) begin
                push_run(sym, len, 1'b1, maxr);
                len = 0;
            end
        end
    endfunction

    task automatic clear_logs();
        acc_q.delete();
        cap_q.delete();
        caps_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bit acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout beat %0h not accepted within 200 cycles", d);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        n_checks++;
        if ({out_valid, out_symbol, out_count, out_last} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b s=%h c=%0d l=%b exp all 0", out_valid, out_symbol, out_count, out_last);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b exp 0", in_ready);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_in_ready got %b exp 1", in_ready);
        end
        clear_logs();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        clear_logs();
        ready_low_cnt = 0;
        mon_low_en = 1;
        send(8'hA1, 0); send(8'hA1, 0); send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 1);
        idle(5);
        mon_low_en = 0;
        build_expected(255);
        n_checks++;
        if (cap_q.size() !== 3 || exp_q.size() !== 3) begin
            n_fail++;
            $display("FAIL basic_npairs got %0d exp 3 (model %0d)", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_pair%0d got %h exp %h", i, cap_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ready_low_cnt !== 1) begin
            n_fail++;
            $display("FAIL basic_tail_cycles got %0d exp 1", ready_low_cnt);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) send(8'h55, (i == 6));
        idle(5);
        build_expected(3);
        n_checks++;
        if (caps_q.size() !== exp_q.size() || exp_q.size() !== 3) begin
            n_fail++;
            $display("FAIL sat_npairs got %0d exp %0d", caps_q.size(), exp_q.size());
        end
        for (int i = 0; i < caps_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (caps_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sat_pair%0d got %h exp %h", i, caps_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (cap_q.size() !== 1 || cap_q[0] !== mk(8'h55, 8'd7, 1'b1)) begin
            n_fail++;
            $display("FAIL sat_wide_pair got %0d pairs exp one (55,7,1)", cap_q.size());
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        clear_logs();
        send(8'h0F, 1);
        n_checks++;
        if ({out_valid, out_symbol, out_count, out_last} !== {1'b1, 8'h0F, 8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_latency got v=%b s=%h c=%0d l=%b exp 1 0f 1 1", out_valid, out_symbol, out_count, out_last);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_back_to_empty in_ready got %b exp 1", in_ready);
        end
        idle(3);
        n_checks++;
        if (cap_q.size() !== 1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_count got %0d pairs valid=%b exp 1 pair valid=0", cap_q.size(), out_valid);
        end
    endtask

    task automatic test_backpressure();
        bit seen = 0;
        out_ready = 1'b0;
        clear_logs();
        fork
            begin
                send(8'd1, 0); send(8'd2, 0); send(8'd3, 1);
            end
            begin
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1;
                        break;
                    end
                end
                n_checks++;
                if (!seen) begin
                    n_fail++;
                    $display("FAIL bp_first_emit got none exp out_valid within 50 cycles");
                end
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    n_checks++;
                    if ({out_valid, out_symbol, out_count, out_last} !== {1'b1, 8'd1, 8'd1, 1'b0}) begin
                        n_fail++;
                        $display("FAIL bp_hold%0d got v=%b s=%h c=%0d l=%b exp 1 01 1 0", k, out_valid, out_symbol, out_count, out_last);
                    end
                    n_checks++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL bp_in_ready%0d got %b exp 0", k, in_ready);
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(6);
        build_expected(255);
        n_checks++;
        if (cap_q.size() !== 3 || exp_q.size() !== 3) begin
            n_fail++;
            $display("FAIL bp_npairs got %0d exp 3", cap_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_pair%0d got %h exp %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        out_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 4; i++) send(8'hAA, 0);
        send(8'h11, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_count !== 8'd4) begin
            n_fail++;
            $display("FAIL mid_pending got v=%b c=%0d exp 1 4", out_valid, out_count);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_symbol, out_count, out_last, in_ready} !== 19'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear got v=%b s=%h c=%0d l=%b r=%b exp all 0", out_valid, out_symbol, out_count, out_last, in_ready);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        out_ready = 1'b1;
        send(8'hBB, 1);
        idle(4);
        n_checks++;
        if (cap_q.size() !== 1 || cap_q[0] !== mk(8'hBB, 8'd1, 1'b1)) begin
            n_fail++;
            $display("FAIL mid_post_frame got %0d pairs first %h exp one (bb,1,1)", cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : pair_t'(0));
        end
    endtask

    task automatic test_back_to_back();
        bit done = 0;
        int in_lasts = 0;
        int out_lasts = 0;
        clear_logs();
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    int len = $urandom_range(1, 12);
                    for (int b = 0; b < len; b++) begin
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                        send(8'($urandom_range(0, 3)) + 8'hE0, (b == len - 1));
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        idle(10);
        build_expected(255);
        n_checks++;
        if (cap_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_npairs got %0d exp %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_pair%0d got %h exp %h", i, cap_q[i], exp_q[i]);
            end
        end
        foreach (acc_q[i]) if (acc_q[i].l) in_lasts++;
        foreach (cap_q[i]) if (cap_q[i].l) out_lasts++;
        n_checks++;
        if (out_lasts !== in_lasts || in_lasts !== 30) begin
            n_fail++;
            $display("FAIL rand_last_align got %0d out_last exp %0d (in_last %0d)", out_lasts, 30, in_lasts);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_single();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
